// File: rtl/wb_stage_buf.sv
// Buffered write-back stage: source mux, two-entry elastic buffer (OUT + SKID)
// toward the register-file write port, zero-register suppression, retire counter.
module wb_stage_buf #(
  parameter int DATA_W      = 19,
  parameter int REG_ADDR_W  = 3,
  parameter int COUNT_W     = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [1:0]            wb_sel_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     alu_data_in,
  input  logic [DATA_W-1:0]     pc_link_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  wr_req_in,
  input  logic                  flush,
  input  logic                  rf_ready,
  output logic [DATA_W-1:0]     register_write_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_en,
  output logic [COUNT_W-1:0]    retired_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [DATA_W-1:0]     r_out_data, w_out_data_next;
  logic [REG_ADDR_W-1:0] r_out_rd, w_out_rd_next;
  logic                  r_out_wr, w_out_wr_next;
  logic [DATA_W-1:0]     r_skid_data, w_skid_data_next;
  logic [REG_ADDR_W-1:0] r_skid_rd, w_skid_rd_next;
  logic                  r_skid_wr, w_skid_wr_next;
  logic [COUNT_W-1:0]    r_count;

  logic [DATA_W-1:0]     w_in_data;
  logic                  w_in_wr;
  logic                  w_out_v;
  logic                  w_accept;
  logic                  w_consume;

  always_comb begin
    w_in_data = mem_data_in;
    case (wb_sel_in)
      2'd0:    w_in_data = mem_data_in;
      2'd1:    w_in_data = alu_data_in;
      2'd2:    w_in_data = pc_link_in;
      default: w_in_data = imm_in;
    endcase
  end

  assign w_in_wr   = wr_req_in && !((ZERO_REG_EN != 0) && (rd_in == '0));
  assign w_out_v   = (r_state != ST_EMPTY);
  assign ready_out = (r_state != ST_FULL);
  assign w_accept  = valid_in && ready_out;
  // Non-writing entries drain even while the register-file port is busy.
  assign w_consume = w_out_v && (rf_ready || !r_out_wr);

  always_comb begin
    w_state_next     = r_state;
    w_out_data_next  = r_out_data;
    w_out_rd_next    = r_out_rd;
    w_out_wr_next    = r_out_wr;
    w_skid_data_next = r_skid_data;
    w_skid_rd_next   = r_skid_rd;
    w_skid_wr_next   = r_skid_wr;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next    = ST_ONE;
            w_out_data_next = w_in_data;
            w_out_rd_next   = rd_in;
            w_out_wr_next   = w_in_wr;
          end
        end
        ST_ONE: begin
          if (w_consume && w_accept) begin
            w_out_data_next = w_in_data;
            w_out_rd_next   = rd_in;
            w_out_wr_next   = w_in_wr;
          end else if (w_consume) begin
            w_state_next = ST_EMPTY;
          end else if (w_accept) begin
            w_state_next     = ST_FULL;
            w_skid_data_next = w_in_data;
            w_skid_rd_next   = rd_in;
            w_skid_wr_next   = w_in_wr;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_next    = ST_ONE;
            w_out_data_next = r_skid_data;
            w_out_rd_next   = r_skid_rd;
            w_out_wr_next   = r_skid_wr;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_wr    <= 1'b0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_wr   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_data  <= w_out_data_next;
      r_out_rd    <= w_out_rd_next;
      r_out_wr    <= w_out_wr_next;
      r_skid_data <= w_skid_data_next;
      r_skid_rd   <= w_skid_rd_next;
      r_skid_wr   <= w_skid_wr_next;
      // A consume in a flush cycle still reaches the register file but is not counted.
      if (w_consume && !flush) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign register_write_data = r_out_data;
  assign rd_out              = r_out_rd;
  assign reg_write_en        = w_out_v && r_out_wr;
  assign retired_count       = r_count;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: vector table, hand-written corner sequences, and a
// randomized run against a queue-based reference model.
module tb_wb_stage_buf;

  localparam logic [18:0] MEM_C = 19'h11111;
  localparam logic [18:0] ALU_C = 19'h12345;
  localparam logic [18:0] PC_C  = 19'h23456;
  localparam logic [18:0] IMM_C = 19'h3ABCD;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  wb_sel_in;
  logic [18:0] mem_data_in, alu_data_in, pc_link_in, imm_in;
  logic [2:0]  rd_in;
  logic        wr_req_in;
  logic        flush;
  logic        rf_ready;
  logic [18:0] register_write_data;
  logic [2:0]  rd_out;
  logic        reg_write_en;
  logic [15:0] retired_count;

  logic        ready_out4;
  logic [18:0] register_write_data4;
  logic [2:0]  rd_out4;
  logic        reg_write_en4;
  logic [3:0]  retired_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_buf u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .wb_sel_in(wb_sel_in), .mem_data_in(mem_data_in), .alu_data_in(alu_data_in),
    .pc_link_in(pc_link_in), .imm_in(imm_in), .rd_in(rd_in), .wr_req_in(wr_req_in),
    .flush(flush), .rf_ready(rf_ready), .register_write_data(register_write_data),
    .rd_out(rd_out), .reg_write_en(reg_write_en), .retired_count(retired_count)
  );

  wb_stage_buf #(.COUNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out4),
    .wb_sel_in(wb_sel_in), .mem_data_in(mem_data_in), .alu_data_in(alu_data_in),
    .pc_link_in(pc_link_in), .imm_in(imm_in), .rd_in(rd_in), .wr_req_in(wr_req_in),
    .flush(flush), .rf_ready(rf_ready), .register_write_data(register_write_data4),
    .rd_out(rd_out4), .reg_write_en(reg_write_en4), .retired_count(retired_count4)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [2:0]  rd;
    logic        wr;
    logic        rf;
    logic        fl;
    logic        e_wen;
    logic        e_chk;
    logic [18:0] e_data;
    logic [2:0]  e_rd;
    logic        e_ready;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [18:0] d;
    logic [2:0]  rd;
    logic        wr;
  } ent_t;

  vec_t vecs[19];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " wen"},   32'(reg_write_en), 32'd0);
    chk({tag, " data"},  32'(register_write_data), 32'd0);
    chk({tag, " rd"},    32'(rd_out), 32'd0);
    chk({tag, " ready"}, 32'(ready_out), 32'd1);
    chk({tag, " count"}, 32'(retired_count), 32'd0);
  endtask

  task automatic randomize_inputs();
    valid_in    = 1'($urandom_range(0, 3) != 0);
    wb_sel_in   = 2'($urandom);
    mem_data_in = 19'($urandom);
    alu_data_in = 19'($urandom);
    pc_link_in  = 19'($urandom);
    imm_in      = 19'($urandom);
    rd_in       = 3'($urandom);
    wr_req_in   = 1'($urandom_range(0, 3) != 0);
    rf_ready    = 1'($urandom_range(0, 3) != 0);
    flush       = 1'($urandom_range(0, 19) == 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1,2'd1,3'd5,1'b1,1'b0,1'b0, 1'b1,1'b1,ALU_C,3'd5,1'b1,16'd0};
    vecs[1]  = '{1'b1,2'd0,3'd1,1'b1,1'b1,1'b0, 1'b1,1'b1,MEM_C,3'd1,1'b1,16'd1};
    vecs[2]  = '{1'b1,2'd1,3'd2,1'b1,1'b1,1'b0, 1'b1,1'b1,ALU_C,3'd2,1'b1,16'd2};
    vecs[3]  = '{1'b1,2'd2,3'd3,1'b1,1'b1,1'b0, 1'b1,1'b1,PC_C, 3'd3,1'b1,16'd3};
    vecs[4]  = '{1'b1,2'd3,3'd4,1'b1,1'b1,1'b0, 1'b1,1'b1,IMM_C,3'd4,1'b1,16'd4};
    vecs[5]  = '{1'b0,2'd0,3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd5};
    vecs[6]  = '{1'b1,2'd1,3'd6,1'b1,1'b0,1'b0, 1'b1,1'b1,ALU_C,3'd6,1'b1,16'd5};
    vecs[7]  = '{1'b1,2'd2,3'd7,1'b1,1'b0,1'b0, 1'b1,1'b1,ALU_C,3'd6,1'b0,16'd5};
    vecs[8]  = '{1'b1,2'd3,3'd1,1'b1,1'b0,1'b0, 1'b1,1'b1,ALU_C,3'd6,1'b0,16'd5};
    vecs[9]  = '{1'b1,2'd3,3'd1,1'b1,1'b1,1'b0, 1'b1,1'b1,PC_C, 3'd7,1'b1,16'd6};
    vecs[10] = '{1'b1,2'd3,3'd1,1'b1,1'b1,1'b0, 1'b1,1'b1,IMM_C,3'd1,1'b1,16'd7};
    vecs[11] = '{1'b0,2'd0,3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd8};
    vecs[12] = '{1'b1,2'd0,3'd0,1'b1,1'b0,1'b0, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd8};
    vecs[13] = '{1'b0,2'd0,3'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd9};
    vecs[14] = '{1'b1,2'd0,3'd2,1'b1,1'b0,1'b0, 1'b1,1'b1,MEM_C,3'd2,1'b1,16'd9};
    vecs[15] = '{1'b1,2'd1,3'd3,1'b1,1'b0,1'b0, 1'b1,1'b1,MEM_C,3'd2,1'b0,16'd9};
    vecs[16] = '{1'b1,2'd0,3'd5,1'b1,1'b0,1'b1, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd9};
    vecs[17] = '{1'b1,2'd2,3'd4,1'b1,1'b0,1'b0, 1'b1,1'b1,PC_C, 3'd4,1'b1,16'd9};
    vecs[18] = '{1'b1,2'd0,3'd5,1'b1,1'b1,1'b1, 1'b0,1'b0,19'd0,3'd0,1'b1,16'd9};

    // Reset held low with random inputs: everything stays cleared.
    reset = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      check_reset_outputs("reset_hold");
      randomize_inputs();
    end
    reset = 1'b1;

    mem_data_in = MEM_C;
    alu_data_in = ALU_C;
    pc_link_in  = PC_C;
    imm_in      = IMM_C;
    for (int i = 0; i < 19; i++) begin
      valid_in  = vecs[i].v;
      wb_sel_in = vecs[i].sel;
      rd_in     = vecs[i].rd;
      wr_req_in = vecs[i].wr;
      rf_ready  = vecs[i].rf;
      flush     = vecs[i].fl;
      step();
      chk($sformatf("vec%0d wen", i),   32'(reg_write_en), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d ready", i), 32'(ready_out), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d count", i), 32'(retired_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_chk) begin
        chk($sformatf("vec%0d data", i), 32'(register_write_data), 32'(vecs[i].e_data));
        chk($sformatf("vec%0d rd", i),   32'(rd_out), 32'(vecs[i].e_rd));
      end
    end

    // Wrap: 17 retirements on a 4-bit counter leave 1.
    flush = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    valid_in = 1'b1; wb_sel_in = 2'd0; rd_in = 3'd1; wr_req_in = 1'b1; rf_ready = 1'b1;
    for (int i = 0; i < 17; i++) step();
    valid_in = 1'b0;
    step();
    chk("wrap count4", 32'(retired_count4), 32'd1);
    chk("wrap count16", 32'(retired_count), 32'd17);

    // Asynchronous reset mid-operation with the buffer full.
    valid_in = 1'b1; rf_ready = 1'b0; rd_in = 3'd3; wb_sel_in = 2'd1;
    step();
    step();
    chk("prefull ready", 32'(ready_out), 32'd0);
    chk("prefull wen", 32'(reg_write_en), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    reset = 1'b1;

    // Randomized run against the reference model.
    q.delete();
    begin
      int   mcount;
      logic m_cons, m_acc;
      ent_t e;
      mcount = 0;
      for (int i = 0; i < 1500; i++) begin
        randomize_inputs();
        m_acc  = valid_in && (q.size() < 2);
        m_cons = (q.size() > 0) && (rf_ready || !q[0].wr);
        case (wb_sel_in)
          2'd0:    e.d = mem_data_in;
          2'd1:    e.d = alu_data_in;
          2'd2:    e.d = pc_link_in;
          default: e.d = imm_in;
        endcase
        e.rd = rd_in;
        e.wr = wr_req_in && (rd_in != 3'd0);
        step();
        if (flush) begin
          q.delete();
        end else begin
          if (m_cons) begin
            void'(q.pop_front());
            mcount++;
          end
          if (m_acc) q.push_back(e);
        end
        chk($sformatf("rnd%0d ready", i), 32'(ready_out), 32'(q.size() < 2));
        chk($sformatf("rnd%0d wen", i), 32'(reg_write_en),
            32'((q.size() > 0) ? q[0].wr : 1'b0));
        if (q.size() > 0 && q[0].wr) begin
          chk($sformatf("rnd%0d data", i), 32'(register_write_data), 32'(q[0].d));
          chk($sformatf("rnd%0d rd", i), 32'(rd_out), 32'(q[0].rd));
        end
        chk($sformatf("rnd%0d count", i), 32'(retired_count), 32'(mcount % 65536));
        chk($sformatf("rnd%0d count4", i), 32'(retired_count4), 32'(mcount % 16));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
